// File: rtl/key_strobe_gen.sv
// Key conditioner and clock-enable generator: synchronizes and debounces a raw key,
// emits a press pulse, and strobes en every STROBE_DIV cycles. Build option KEY_STROBE_STEP_EN.
module key_strobe_gen #(
    parameter int STROBE_DIV      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic a,
    output logic en,
    output logic key_press
);

    localparam int PW = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(STROBE_DIV - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          key_s;
    logic [PW-1:0] pre;
    logic [DW-1:0] db_cnt;
    logic          accept;
    logic          press_next;
    logic          strobe_next;
    logic          en_next;

    // A changed level is taken once it has been seen on DEBOUNCE_CYCLES consecutive edges.
    assign accept      = (key_s != a) && (db_cnt == DB_MAX);
    assign press_next  = accept && key_s;
    assign strobe_next = (pre == PRE_MAX);

`ifdef KEY_STROBE_STEP_EN
    // Each accepted press also advances the downstream FSM by one step.
    assign en_next = strobe_next | press_next;
`else
    assign en_next = strobe_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            key_s     <= 1'b0;
            a         <= 1'b0;
            db_cnt    <= '0;
            key_press <= 1'b0;
            en        <= 1'b0;
            pre       <= '0;
        end else begin
            sync1 <= key_raw;
            key_s <= sync1;

            if (key_s == a) begin
                db_cnt <= '0;
            end else if (accept) begin
                a      <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end

            key_press <= press_next;
            en        <= en_next;

            // en is registered from the prescaler value, so it lands one cycle after the wrap
            // value and the first pulse falls on the STROBE_DIV-th cycle after release.
            if (strobe_next) pre <= '0;
            else             pre <= pre + PW'(1);
        end
    end

endmodule

// File: tb/tb_key_strobe_gen.sv
// Directed bench for key_strobe_gen: strobe timing, clean press/release, glitch rejection,
// reset mid-debounce, and a STROBE_DIV=1 instance sharing clock, reset and key.
module tb_key_strobe_gen;

`ifdef KEY_STROBE_STEP_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic key_raw;
    logic a8, en8, kp8;
    logic a1, en1, kp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_strobe_gen #(.STROBE_DIV(8), .DEBOUNCE_CYCLES(4)) dut8 (
        .clk(clk), .reset(reset), .key_raw(key_raw),
        .a(a8), .en(en8), .key_press(kp8)
    );

    key_strobe_gen #(.STROBE_DIV(1), .DEBOUNCE_CYCLES(4)) dut1 (
        .clk(clk), .reset(reset), .key_raw(key_raw),
        .a(a1), .en(en1), .key_press(kp1)
    );

    task automatic chk(input string tag, input int k, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc %0d: observed %b expected %b", tag, k, obs, exp_v);
        end
    endtask

    task automatic chk_all(input int k, input logic ea, input logic ekp, input logic een8,
                           input logic een1);
        chk("a8", k, a8, ea);
        chk("key_press8", k, kp8, ekp);
        chk("en8", k, en8, een8);
        chk("a1", k, a1, ea);
        chk("key_press1", k, kp1, ekp);
        chk("en1", k, en1, een1);
    endtask

    initial begin
        logic ea, ekp, een;

        // Async reset before any clock edge.
        reset   = 1'b1;
        key_raw = 1'b0;
        #2 reset = 1'b0;
        #1 chk_all(0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk_all(0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Cycle k is the cycle after post-release edge k.
        // Press sampled at edge 30 -> a rises at edge 35; release sampled at 40 -> a falls at 45;
        // glitch sampled at edges 50..52 (3 cycles) is rejected.
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            @(negedge clk);
            ea  = (k >= 35) && (k < 45);
            ekp = (k == 35);
            een = ((k % 8) == 0) || (STEP && (k == 35));
            chk_all(k, ea, ekp, een, 1'b1);
            key_raw = ((k + 1 >= 30) && (k + 1 < 40)) ||
                      ((k + 1 >= 50) && (k + 1 < 53)) ||
                      (k + 1 >= 61);
        end

        // key_raw sampled high from edge 61, key_s high after 62, counter at 2 after 64:
        // reset now aborts the debounce and clears outputs immediately.
        reset = 1'b0;
        #1 chk_all(100, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk_all(101, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Key held high: sampled at first edge after release -> a rises at edge 1+1+4 = 6.
        for (int r = 1; r <= 12; r++) begin
            @(posedge clk);
            @(negedge clk);
            ea  = (r >= 6);
            ekp = (r == 6);
            een = ((r % 8) == 0) || (STEP && (r == 6));
            chk_all(200 + r, ea, ekp, een, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
